// File: rtl/branch_resolve_bht_pkg.sv
// branch_resolve_bht_pkg: branch codes, pc_sel encodings and counter reset value
package branch_resolve_bht_pkg;
  localparam logic [3:0] NPC_NONE = 4'd0;
  localparam logic [3:0] NPC_BEQ  = 4'd1;
  localparam logic [3:0] NPC_BNE  = 4'd2;
  localparam logic [3:0] NPC_BLEZ = 4'd3;
  localparam logic [3:0] NPC_BGTZ = 4'd4;
  localparam logic [3:0] NPC_BLTZ = 4'd5;
  localparam logic [3:0] NPC_BGEZ = 4'd6;
  localparam logic [3:0] NPC_J    = 4'd7;
  localparam logic [3:0] NPC_JAL  = 4'd8;
  localparam logic [3:0] NPC_JR   = 4'd9;
  localparam logic [3:0] NPC_JALR = 4'd10;
  localparam logic [1:0] PC_ADD4     = 2'd0;
  localparam logic [1:0] PC_NPC      = 2'd1;
  localparam logic [1:0] PC_NPC_REG  = 2'd2;
  localparam logic [1:0] PC_FALLTHRU = 2'd3;
  // Weakly-not-taken; collapses to 0 when CTR_W=1
  function automatic int ctr_rst_val(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/bht_ctr_table.sv
// bht_ctr_table: saturating counter array, one async read port, one inc/dec write port
module bht_ctr_table
  import branch_resolve_bht_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_W       = 2,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(ctr_rst_val(CTR_W));
  logic [CTR_W-1:0] r_ctr [BHT_ENTRIES];
  logic [CTR_W-1:0] w_cur, w_nxt;
  assign rd_ctr = r_ctr[rd_idx];
  assign w_cur  = r_ctr[wr_idx];
  assign w_nxt  = wr_taken ? ((&w_cur) ? w_cur : w_cur + 1'b1)
                           : ((|w_cur) ? w_cur - 1'b1 : w_cur);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_ctr[i] <= RST_VAL;
    end else if (wr_en) begin
      r_ctr[wr_idx] <= w_nxt;
    end
  end
endmodule

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: D-stage branch resolution with a PC-indexed saturating-counter
// predictor, mispredict redirect and performance counters.
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_W       = 2,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_f,
  output logic              pred_taken_f,
  input  logic [3:0]        br_type_d,
  input  logic [31:0]       pc_d,
  input  logic              pred_taken_d,
  input  logic [DATA_W-1:0] rs_d,
  input  logic [DATA_W-1:0] rt_d,
  input  logic              stall_d,
  input  logic              stat_clr,
  output logic [1:0]        pc_sel_d,
  output logic              mispredict_d,
  output logic              cond_taken_d,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  logic             w_cond, w_jump, w_jreg, w_train, w_neg, w_zero;
  logic [CTR_W-1:0] w_ctr_f;
  logic [STAT_W-1:0] r_branches, r_mispredicts;
  assign w_neg   = rs_d[DATA_W-1];
  assign w_zero  = ~|rs_d;
  assign w_cond  = br_type_d inside {NPC_BEQ, NPC_BNE, NPC_BLEZ, NPC_BGTZ, NPC_BLTZ, NPC_BGEZ};
  assign w_jump  = br_type_d inside {NPC_J, NPC_JAL};
  assign w_jreg  = br_type_d inside {NPC_JR, NPC_JALR};
  assign w_train = w_cond & ~stall_d;
  always_comb begin
    cond_taken_d = br_type_d == NPC_BEQ  ? rs_d == rt_d :
                   br_type_d == NPC_BNE  ? rs_d != rt_d :
                   br_type_d == NPC_BLEZ ? w_neg | w_zero :
                   br_type_d == NPC_BGTZ ? ~w_neg & ~w_zero :
                   br_type_d == NPC_BLTZ ? w_neg :
                   br_type_d == NPC_BGEZ ? ~w_neg : 1'b0;
    mispredict_d = w_train & (cond_taken_d != pred_taken_d);
    pc_sel_d     = w_jump ? PC_NPC :
                   w_jreg ? PC_NPC_REG :
                   mispredict_d ? (cond_taken_d ? PC_NPC : PC_FALLTHRU) : PC_ADD4;
  end
  bht_ctr_table #(.BHT_ENTRIES(BHT_ENTRIES), .CTR_W(CTR_W)) u_table (
    .clk     (clk),
    .rst_n   (reset),
    .rd_idx  (pc_f[IDX_W+1:2]),
    .rd_ctr  (w_ctr_f),
    .wr_en   (w_train),
    .wr_idx  (pc_d[IDX_W+1:2]),
    .wr_taken(cond_taken_d)
  );
  assign pred_taken_f = w_ctr_f[CTR_W-1];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_branches    <= '0;
      r_mispredicts <= '0;
    end else if (stat_clr) begin
      r_branches    <= '0;
      r_mispredicts <= '0;
    end else if (w_train) begin
      r_branches    <= r_branches + 1'b1;
      r_mispredicts <= r_mispredicts + STAT_W'(mispredict_d);
    end
  end
  assign stat_branches    = r_branches;
  assign stat_mispredicts = r_mispredicts;
endmodule
